// File: rtl/p4_router_pkg.sv
// p4_router_pkg: shared widths, metadata entry type and egress-align FSM states
package p4_router_pkg;
  localparam int ING_PORT_ID_WIDTH = 8;
  localparam int EGR_SPEC_ID_WIDTH = 8;
  localparam logic [EGR_SPEC_ID_WIDTH-1:0] P4_EGR_SPEC_DROP = '1;
  typedef struct packed {
    logic [ING_PORT_ID_WIDTH-1:0] ing_port;
    logic [EGR_SPEC_ID_WIDTH-1:0] egr_spec;
  } USER_META_DATA_T;
  typedef enum logic [1:0] {IDLE, PASS, DROP} align_state_t;
endpackage

// File: rtl/p4_router_egress_meta_align_if.sv
// AXIS_int: AXI-stream packet bus; clk comes from the block clock, sresetn is carried but unused here
interface AXIS_int #(parameter int DATA_BYTES = 8) (input logic clk);
  logic sresetn;
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0] tkeep;
  logic tvalid;
  logic tready;
  logic tlast;
  modport Master (input clk, sresetn, tready, output tdata, tkeep, tvalid, tlast);
  modport Slave (input clk, sresetn, tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/p4_router_meta_fifo.sv
// p4_router_meta_fifo: first-word-fall-through metadata queue with level, full and empty
module p4_router_meta_fifo
  import p4_router_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type T = USER_META_DATA_T
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  // a push at full is only accepted when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/p4_router_egress_meta_align.sv
// p4_router_egress_meta_align: re-attaches queued VNP4 metadata to each packet and discards drop-coded packets
module p4_router_egress_meta_align
  import p4_router_pkg::*;
#(
  parameter int META_FIFO_DEPTH = 8,
  parameter logic [EGR_SPEC_ID_WIDTH-1:0] DROP_EGR_SPEC = P4_EGR_SPEC_DROP
) (
  input  logic clk,
  input  logic areset,
  AXIS_int.Slave packet_data_in,
  input  logic [ING_PORT_ID_WIDTH-1:0] meta_in_ing_port,
  input  logic [EGR_SPEC_ID_WIDTH-1:0] meta_in_egr_spec,
  input  logic meta_in_valid,
  AXIS_int.Master packet_data_out,
  output logic [ING_PORT_ID_WIDTH-1:0] out_ing_port,
  output logic [EGR_SPEC_ID_WIDTH-1:0] out_egr_spec,
  output logic [31:0] drop_count,
  output logic meta_overflow,
  output logic [$clog2(META_FIFO_DEPTH):0] meta_fifo_level
);
  align_state_t state, next;
  USER_META_DATA_T meta_word, head, cur_meta;
  logic full, empty, pop, in_ready, out_ready, load;
  assign meta_word = {meta_in_ing_port, meta_in_egr_spec};
  p4_router_meta_fifo #(.DEPTH(META_FIFO_DEPTH), .T(USER_META_DATA_T)) u_fifo (
    .clk(clk), .rst(areset), .push(meta_in_valid), .din(meta_word), .pop(pop),
    .dout(head), .full(full), .empty(empty), .level(meta_fifo_level)
  );
  assign out_ready = !packet_data_out.tvalid || packet_data_out.tready;
  assign load = state == PASS && packet_data_in.tvalid && out_ready;
  assign packet_data_in.tready = in_ready;
  always_comb begin
    next = state;
    pop = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        next = empty ? IDLE : (head.egr_spec == DROP_EGR_SPEC ? DROP : PASS);
      end
      PASS: begin
        in_ready = out_ready;
        next = (load && packet_data_in.tlast) ? IDLE : PASS;
      end
      default: begin
        in_ready = 1'b1;
        next = (packet_data_in.tvalid && packet_data_in.tlast) ? IDLE : DROP;
      end
    endcase
  end
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state <= IDLE;
      cur_meta <= '0;
      packet_data_out.tvalid <= 1'b0;
      packet_data_out.tlast <= 1'b0;
      packet_data_out.tdata <= '0;
      packet_data_out.tkeep <= '0;
      out_ing_port <= '0;
      out_egr_spec <= '0;
      drop_count <= '0;
      meta_overflow <= 1'b0;
    end else begin
      state <= next;
      if (pop) cur_meta <= head;
      if (load) begin
        packet_data_out.tvalid <= 1'b1;
        packet_data_out.tlast <= packet_data_in.tlast;
        packet_data_out.tdata <= packet_data_in.tdata;
        packet_data_out.tkeep <= packet_data_in.tkeep;
        out_ing_port <= cur_meta.ing_port;
        out_egr_spec <= cur_meta.egr_spec;
      end else if (packet_data_out.tready) packet_data_out.tvalid <= 1'b0;
      if (state == DROP && packet_data_in.tvalid && packet_data_in.tlast && drop_count != '1)
        drop_count <= drop_count + 32'd1;
      if (meta_in_valid && full && !pop) meta_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_p4_router_egress_meta_align.sv
// tb_p4_router_egress_meta_align: directed vectors plus an output scoreboard for the egress metadata aligner
module tb_p4_router_egress_meta_align;
  logic clk = 1'b0;
  logic areset;
  logic [7:0] meta_in_ing_port, meta_in_egr_spec;
  logic meta_in_valid;
  logic [7:0] out_ing_port, out_egr_spec;
  logic [31:0] drop_count;
  logic meta_overflow;
  logic [3:0] meta_fifo_level;
  AXIS_int #(.DATA_BYTES(4)) in_if (.clk(clk));
  AXIS_int #(.DATA_BYTES(4)) out_if (.clk(clk));
  p4_router_egress_meta_align dut (
    .clk(clk), .areset(areset), .packet_data_in(in_if),
    .meta_in_ing_port(meta_in_ing_port), .meta_in_egr_spec(meta_in_egr_spec), .meta_in_valid(meta_in_valid),
    .packet_data_out(out_if), .out_ing_port(out_ing_port), .out_egr_spec(out_egr_spec),
    .drop_count(drop_count), .meta_overflow(meta_overflow), .meta_fifo_level(meta_fifo_level)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0, cyc = 0, beats_seen = 0, first_cyc = 0, last_cyc = 0;
  bit mon_en = 1'b0, rnd_rdy = 1'b0, prev_stall = 1'b0;
  logic [63:0] prev_word;
  logic [63:0] exp_q [$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] pack(input logic [31:0] d, input logic [3:0] k, input logic l,
                                       input logic [7:0] ing, input logic [7:0] egr);
    return {11'b0, l, ing, egr, k, d};
  endfunction
  always @(posedge clk) cyc++;
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    logic [63:0] got;
    got = pack(out_if.tdata, out_if.tkeep, out_if.tlast, out_ing_port, out_egr_spec);
    if (!mon_en || areset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_if.tvalid), 64'd1);
        chk("hold_word", got, prev_word);
      end
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) chk("extra_beat", got, 64'hdead);
        else chk("beat", got, exp_q.pop_front());
        if (beats_seen == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats_seen++;
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_word = got;
    end
  end
  task automatic meta(input logic [7:0] ing, input logic [7:0] egr);
    meta_in_ing_port = ing;
    meta_in_egr_spec = egr;
    meta_in_valid = 1'b1;
    @(posedge clk);
    #1 meta_in_valid = 1'b0;
  endtask
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    in_if.tvalid = 1'b1;
    in_if.tdata = d;
    in_if.tkeep = k;
    in_if.tlast = l;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_if.tready) break;
      if (t == 300) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1 in_if.tvalid = 1'b0;
  endtask
  task automatic send_pkt(input logic [7:0] ing, input logic [7:0] egr, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      if (egr != 8'hFF) exp_q.push_back(pack(base + 32'(b), (b == n - 1) ? 4'h3 : 4'hF, b == n - 1, ing, egr));
      drive_beat(base + 32'(b), (b == n - 1) ? 4'h3 : 4'hF, b == n - 1);
    end
  endtask
  task automatic wait_drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    areset = 1'b1;
    meta_in_valid = 1'b0;
    meta_in_ing_port = '0;
    meta_in_egr_spec = '0;
    in_if.sresetn = 1'b1;
    out_if.sresetn = 1'b1;
    in_if.tvalid = 1'b0;
    in_if.tdata = '0;
    in_if.tkeep = '0;
    in_if.tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_word", pack(out_if.tdata, out_if.tkeep, out_if.tlast, out_ing_port, out_egr_spec), 64'd0);
    chk("rst_out_valid", 64'(out_if.tvalid), 64'd0);
    chk("rst_status", {drop_count, 27'd0, meta_overflow, meta_fifo_level}, 64'd0);
    chk("rst_in_ready", 64'(in_if.tready), 64'd0);
    @(posedge clk);
    #1 areset = 1'b0;
    mon_en = 1'b1;
    // three queued packets back to back: 12 beats plus two IDLE gaps
    meta(8'd1, 8'd5);
    meta(8'd2, 8'd6);
    meta(8'd3, 8'd7);
    beats_seen = 0;
    send_pkt(8'd1, 8'd5, 4, 32'h100);
    send_pkt(8'd2, 8'd6, 4, 32'h200);
    send_pkt(8'd3, 8'd7, 4, 32'h300);
    wait_drain();
    chk("b2b_beats", 64'(beats_seen), 64'd12);
    chk("b2b_span", 64'(last_cyc - first_cyc), 64'd13);
    chk("b2b_drops", 64'(drop_count), 64'd0);
    meta(8'd1, 8'd10);
    meta(8'd2, 8'hFF);
    meta(8'd3, 8'd11);
    send_pkt(8'd1, 8'd10, 3, 32'h1100);
    send_pkt(8'd2, 8'hFF, 3, 32'h1200);
    send_pkt(8'd3, 8'd11, 3, 32'h1300);
    wait_drain();
    chk("drop_count", 64'(drop_count), 64'd1);
    // beat waits in IDLE until metadata arrives; ready rises two cycles after the pulse
    exp_q.push_back(pack(32'h400, 4'hF, 1'b0, 8'd4, 8'd9));
    exp_q.push_back(pack(32'h401, 4'h3, 1'b1, 8'd4, 8'd9));
    in_if.tdata = 32'h400;
    in_if.tkeep = 4'hF;
    in_if.tlast = 1'b0;
    in_if.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("early_ready", 64'(in_if.tready), 64'd0);
    end
    @(posedge clk);
    #1;
    meta_in_ing_port = 8'd4;
    meta_in_egr_spec = 8'd9;
    meta_in_valid = 1'b1;
    @(negedge clk);
    chk("ready_n", 64'(in_if.tready), 64'd0);
    @(posedge clk);
    #1 meta_in_valid = 1'b0;
    @(negedge clk);
    chk("ready_n1", 64'(in_if.tready), 64'd0);
    @(negedge clk);
    chk("ready_n2", 64'(in_if.tready), 64'd1);
    @(posedge clk);
    #1 drive_beat(32'h401, 4'h3, 1'b1);
    wait_drain();
    rnd_rdy = 1'b1;
    for (int p = 0; p < 100; p++) begin
      logic [7:0] ing, egr;
      ing = 8'($urandom_range(0, 255));
      egr = 8'($urandom_range(0, 254));
      meta(ing, egr);
      send_pkt(ing, egr, $urandom_range(1, 4), 32'(p) << 8);
    end
    wait_drain();
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    // with no packets, the first entry moves into cur_meta, so the queue fills on the 9th pulse
    for (int i = 0; i < 9; i++) meta(8'(20 + i), 8'(30 + i));
    chk("level_full", 64'(meta_fifo_level), 64'd8);
    chk("ovf_before", 64'(meta_overflow), 64'd0);
    meta(8'd29, 8'd39);
    chk("level_after_ovf", 64'(meta_fifo_level), 64'd8);
    chk("ovf_set", 64'(meta_overflow), 64'd1);
    for (int i = 0; i < 9; i++) send_pkt(8'(20 + i), 8'(30 + i), 1, 32'h2000 + 32'(i));
    wait_drain();
    chk("level_empty", 64'(meta_fifo_level), 64'd0);
    chk("ovf_sticky", 64'(meta_overflow), 64'd1);
    mon_en = 1'b0;
    meta(8'd5, 8'd12);
    meta(8'd6, 8'd13);
    drive_beat(32'h500, 4'hF, 1'b0);
    drive_beat(32'h501, 4'hF, 1'b0);
    chk("pre_rst_valid", 64'(out_if.tvalid), 64'd1);
    chk("pre_rst_level", 64'(meta_fifo_level), 64'd1);
    in_if.tdata = 32'h502;
    in_if.tvalid = 1'b1;
    #1 areset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_if.tvalid), 64'd0);
    chk("mid_rst_word", pack(out_if.tdata, out_if.tkeep, out_if.tlast, out_ing_port, out_egr_spec), 64'd0);
    chk("mid_rst_status", {drop_count, 27'd0, meta_overflow, meta_fifo_level}, 64'd0);
    chk("mid_rst_ready", 64'(in_if.tready), 64'd0);
    in_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    meta(8'd7, 8'd14);
    send_pkt(8'd7, 8'd14, 4, 32'h700);
    wait_drain();
    chk("post_rst_drops", 64'(drop_count), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
